// File: rtl/microcode_sequencer_pkg.sv
// Shared microcode definitions: address defaults, control-word field layout,
// branch-type and condition encodings, sequencer state encoding.
package pa_microcode;

    localparam int unsigned U_ADDR_W_DEF = 14;
    localparam int unsigned OPC_W        = 8;
    localparam int unsigned STEP_W       = 6;
    localparam int unsigned OFF_W        = 7;
    localparam int unsigned FLAG_W       = 4;
    localparam int unsigned CW_W         = 112;
    localparam int unsigned CW_FIELDS_W  = 17;

    localparam logic [13:0] FETCH_ADDR_DEF = 14'h0000;
    localparam logic [13:0] IRQ_ADDR_DEF   = 14'h3FC0;

    // Flag bit positions inside {OF,SF,CF,ZF}
    localparam int unsigned FLAG_ZF = 0;
    localparam int unsigned FLAG_CF = 1;
    localparam int unsigned FLAG_SF = 2;
    localparam int unsigned FLAG_OF = 3;

    typedef enum logic [1:0] {
        TYP_SEQ      = 2'b00,
        TYP_BRANCH   = 2'b01,
        TYP_DISPATCH = 2'b10,
        TYP_FETCH    = 2'b11
    } typ_e;

    // Codes 8..15 are reserved and evaluate false
    typedef enum logic [3:0] {
        COND_ZF     = 4'd0,
        COND_CF     = 4'd1,
        COND_SF     = 4'd2,
        COND_OF     = 4'd3,
        COND_LT     = 4'd4,
        COND_LE     = 4'd5,
        COND_ULE    = 4'd6,
        COND_ALWAYS = 4'd7
    } cond_sel_e;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Sequencer fields occupy the low 17 bits; the rest belongs to the datapath
    typedef struct packed {
        logic [CW_W-CW_FIELDS_W-1:0] rsvd;
        logic                        ir_wrt;
        logic                        escape;
        logic [3:0]                  cond_sel;
        logic                        cond_flag_src;
        logic                        cond_invert;
        logic [OFF_W-1:0]            offset;
        typ_e                        typ;
    } ucw_t;

endpackage

// File: rtl/microcode_sequencer_if.sv
// Bus between the micro-ROM / datapath side and the microcode sequencer.
interface microcode_sequencer_if
    import pa_microcode::*;
#(
    parameter int unsigned U_ADDR_W = U_ADDR_W_DEF
) ();

    logic [CW_W-1:0]     control_word;
    logic [OPC_W-1:0]    data_bus;
    logic [FLAG_W-1:0]   status_flags;
    logic [FLAG_W-1:0]   u_flags;
    logic                mem_wait;
    logic                irq_pending;
    logic                halt_req;
    logic [U_ADDR_W-1:0] u_addr;
    logic [OPC_W-1:0]    ir;
    logic                halted;
    logic                cw_valid;

    modport master (
        output control_word, data_bus, status_flags, u_flags,
               mem_wait, irq_pending, halt_req,
        input  u_addr, ir, halted, cw_valid
    );

    modport slave (
        input  control_word, data_bus, status_flags, u_flags,
               mem_wait, irq_pending, halt_req,
        output u_addr, ir, halted, cw_valid
    );

endinterface

// File: rtl/useq_cond_eval.sv
// Branch condition evaluator: selects flag source, decodes cond_sel, applies invert.
module useq_cond_eval
    import pa_microcode::*;
(
    input  logic [FLAG_W-1:0] i_status_flags,
    input  logic [FLAG_W-1:0] i_u_flags,
    input  logic [3:0]        i_cond_sel,
    input  logic              i_cond_invert,
    input  logic              i_cond_flag_src,
    output logic              o_cond_true_c
);

    logic [FLAG_W-1:0] w_flags;
    logic              w_lt;
    logic              w_raw;

    // Pick flag vector, then decode the selected predicate
    always_comb begin
        w_flags = i_cond_flag_src ? i_u_flags : i_status_flags;
        w_lt    = w_flags[FLAG_SF] ^ w_flags[FLAG_OF];
        w_raw   = 1'b0;
        case (i_cond_sel)
            COND_ZF:     w_raw = w_flags[FLAG_ZF];
            COND_CF:     w_raw = w_flags[FLAG_CF];
            COND_SF:     w_raw = w_flags[FLAG_SF];
            COND_OF:     w_raw = w_flags[FLAG_OF];
            COND_LT:     w_raw = w_lt;
            COND_LE:     w_raw = w_lt | w_flags[FLAG_ZF];
            COND_ULE:    w_raw = w_flags[FLAG_CF] | w_flags[FLAG_ZF];
            COND_ALWAYS: w_raw = 1'b1;
            default:     w_raw = 1'b0;
        endcase
    end

    assign o_cond_true_c = w_raw ^ i_cond_invert;

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: computes the next micro-address (seq/branch/dispatch/fetch),
// owns the instruction register, and stalls on memory wait or halts at a fetch
// boundary. Optional build macro MICROCODE_SEQUENCER_IRQ_EN enables interrupt
// entry at fetch boundaries and interrupt wake-up from HALT.
module microcode_sequencer
    import pa_microcode::*;
#(
    parameter int unsigned         U_ADDR_W   = U_ADDR_W_DEF,
    parameter logic [U_ADDR_W-1:0] FETCH_ADDR = U_ADDR_W'(FETCH_ADDR_DEF),
    parameter logic [U_ADDR_W-1:0] IRQ_ADDR   = U_ADDR_W'(IRQ_ADDR_DEF)
) (
    input  logic                   clk,
    input  logic                   arst_n,
    microcode_sequencer_if.slave   bus
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [U_ADDR_W-1:0] r_u_addr;
    logic [U_ADDR_W-1:0] w_u_addr_nxt;
    logic [OPC_W-1:0]    r_ir;
    logic [OPC_W-1:0]    w_ir_nxt;
    logic                r_halted;
    logic                r_halt_pend;
    logic                w_halt_pend;
    logic                w_halt_pend_nxt;

    ucw_t                w_cw;
    logic                w_cond_true_c;
    logic [U_ADDR_W-1:0] w_off_ext;
    logic [U_ADDR_W-1:0] w_addr_inc;
    logic [U_ADDR_W-1:0] w_addr_br;
    logic [U_ADDR_W-1:0] w_addr_disp;
    logic                w_unused_cw;

    assign w_cw        = ucw_t'(bus.control_word);
    assign w_unused_cw = |w_cw.rsvd;

    // Address candidates; all arithmetic wraps modulo 2^U_ADDR_W
    assign w_off_ext   = {{(U_ADDR_W-OFF_W){w_cw.offset[OFF_W-1]}}, w_cw.offset};
    assign w_addr_inc  = r_u_addr + U_ADDR_W'(1);
    assign w_addr_br   = r_u_addr + w_off_ext;
    assign w_addr_disp = (w_cw.escape && w_cw.ir_wrt)
                       ? U_ADDR_W'({bus.data_bus, STEP_W'(0)})
                       : U_ADDR_W'({r_ir, STEP_W'(0)});

    // A halt request seen this cycle counts at a fetch in the same cycle
    assign w_halt_pend = r_halt_pend | bus.halt_req;

    useq_cond_eval u_cond_eval (
        .i_status_flags  (bus.status_flags),
        .i_u_flags       (bus.u_flags),
        .i_cond_sel      (w_cw.cond_sel),
        .i_cond_invert   (w_cw.cond_invert),
        .i_cond_flag_src (w_cw.cond_flag_src),
        .o_cond_true_c   (w_cond_true_c)
    );

`ifndef MICROCODE_SEQUENCER_IRQ_EN
    logic w_unused_irq;
    assign w_unused_irq = bus.irq_pending | (|IRQ_ADDR);
`endif

    // State, micro-address, IR, halt flag and halt latch registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= ST_RESET;
            r_u_addr    <= FETCH_ADDR;
            r_ir        <= '0;
            r_halted    <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_u_addr    <= w_u_addr_nxt;
            r_ir        <= w_ir_nxt;
            r_halted    <= (w_state_nxt == ST_HALT);
            r_halt_pend <= w_halt_pend_nxt;
        end
    end

    // Next state / next address; a microinstruction executes only in RUN without wait
    always_comb begin
        w_state_nxt     = r_state;
        w_u_addr_nxt    = r_u_addr;
        w_ir_nxt        = r_ir;
        w_halt_pend_nxt = w_halt_pend;
        case (r_state)
            ST_RESET: begin
                w_state_nxt  = ST_RUN;
                w_u_addr_nxt = FETCH_ADDR;
            end
            ST_RUN: begin
                if (bus.mem_wait) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    if (w_cw.ir_wrt) begin
                        w_ir_nxt = bus.data_bus;
                    end
                    case (w_cw.typ)
                        TYP_SEQ:      w_u_addr_nxt = w_addr_inc;
                        TYP_BRANCH:   w_u_addr_nxt = w_cond_true_c ? w_addr_br : w_addr_inc;
                        TYP_DISPATCH: w_u_addr_nxt = w_addr_disp;
                        TYP_FETCH: begin
`ifdef MICROCODE_SEQUENCER_IRQ_EN
                            if (bus.irq_pending) begin
                                w_u_addr_nxt = IRQ_ADDR;
                            end else begin
                                w_u_addr_nxt = FETCH_ADDR;
                                if (w_halt_pend) begin
                                    w_state_nxt = ST_HALT;
                                end
                            end
`else
                            w_u_addr_nxt = FETCH_ADDR;
                            if (w_halt_pend) begin
                                w_state_nxt = ST_HALT;
                            end
`endif
                        end
                        default:      w_u_addr_nxt = w_addr_inc;
                    endcase
                end
            end
            // Held word is re-presented in RUN so it executes exactly once
            ST_WAIT: begin
                if (!bus.mem_wait) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
`ifdef MICROCODE_SEQUENCER_IRQ_EN
                if (bus.irq_pending) begin
                    w_state_nxt     = ST_RUN;
                    w_u_addr_nxt    = IRQ_ADDR;
                    w_halt_pend_nxt = 1'b0;
                end
`endif
            end
            default: begin
                w_state_nxt  = ST_RESET;
                w_u_addr_nxt = FETCH_ADDR;
            end
        endcase
    end

    assign bus.u_addr = r_u_addr;
    assign bus.ir     = r_ir;
    assign bus.halted = r_halted;
    // Combinational so write strobes are suppressed in the same cycle mem_wait rises
    assign bus.cw_valid = (r_state == ST_RUN) && !bus.mem_wait;

endmodule
